// File: rtl/baud_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : baud_pkg
// | Brief   : Reset-default divisor constants and width helper for the baud generator.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package baud_pkg;

  localparam int DEF_DIV  = 325;
  localparam int DEF_FRAC = 8;

  // Width needed to count 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frac_divider.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : frac_divider
// | Brief   : Fractional clock divider producing the oversample tick.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module frac_divider #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              resync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              period_end,
  output logic              os_tick
);

  localparam logic [DIV_W:0] c_min_div = (DIV_W + 1)'(2);
  localparam logic [DIV_W:0] c_cnt_one = (DIV_W + 1)'(1);

  logic [DIV_W:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic            r_carry;

  logic [DIV_W:0]  w_div_ext;
  logic [DIV_W:0]  w_div_eff;
  logic [DIV_W:0]  w_period;
  logic [FRAC_W:0] w_acc_sum;

  // One extra counter bit so that D+1 never overflows at the maximum divisor.
  always_comb begin
    w_div_ext  = {1'b0, div_int};
    w_div_eff  = (w_div_ext < c_min_div) ? c_min_div : w_div_ext;
    w_period   = w_div_eff + {{DIV_W{1'b0}}, r_carry};
    w_acc_sum  = {1'b0, r_acc} + {1'b0, div_frac};
    period_end = enable && !resync && (r_cnt == w_period);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_cnt   <= c_cnt_one;
      r_acc   <= '0;
      r_carry <= 1'b0;
      os_tick <= 1'b0;
    end else if (!enable || resync) begin
      r_cnt   <= c_cnt_one;
      r_acc   <= '0;
      r_carry <= 1'b0;
      os_tick <= 1'b0;
    end else if (period_end) begin
      r_cnt            <= c_cnt_one;
      {r_carry, r_acc} <= w_acc_sum;
      os_tick          <= 1'b1;
    end else begin
      r_cnt   <= r_cnt + c_cnt_one;
      os_tick <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/baud_tick_generator.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : baud_tick_generator
// | Brief   : UART baud generator: oversample, mid-bit and bit-rate ticks.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module baud_tick_generator #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_DIV    = baud_pkg::DEF_DIV,
  parameter int DEF_FRAC   = baud_pkg::DEF_FRAC
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              resync,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              busy
);

  import baud_pkg::*;

  localparam int                c_os_w    = clog2(OVERSAMPLE);
  localparam logic [c_os_w-1:0] c_os_mid  = c_os_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_os_w-1:0] c_os_last = c_os_w'(OVERSAMPLE - 1);
  localparam logic [c_os_w-1:0] c_os_one  = c_os_w'(1);

  logic [DIV_W-1:0]  r_div_int;
  logic [FRAC_W-1:0] r_div_frac;
  logic [DIV_W-1:0]  r_shadow_int;
  logic [FRAC_W-1:0] r_shadow_frac;
  logic              r_busy;
  logic [c_os_w-1:0] r_os_cnt;
  logic              r_mid_tick;
  logic              r_bit_tick;
  logic              w_period_end;
  logic              w_os_tick;

  frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_divider (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .resync     (resync),
    .div_int    (r_div_int),
    .div_frac   (r_div_frac),
    .period_end (w_period_end),
    .os_tick    (w_os_tick)
  );

  // A new divisor takes effect only on a period boundary, or at once while idle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_div_int     <= DIV_W'(DEF_DIV);
      r_div_frac    <= FRAC_W'(DEF_FRAC);
      r_shadow_int  <= '0;
      r_shadow_frac <= '0;
      r_busy        <= 1'b0;
    end else if (div_load) begin
      r_shadow_int  <= div_int;
      r_shadow_frac <= div_frac;
      r_busy        <= 1'b1;
    end else if (r_busy && (w_period_end || !enable)) begin
      r_div_int  <= r_shadow_int;
      r_div_frac <= r_shadow_frac;
      r_busy     <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_os_cnt   <= '0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (!enable || resync) begin
      r_os_cnt   <= '0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (w_period_end) begin
      r_os_cnt   <= r_os_cnt + c_os_one;
      r_mid_tick <= (r_os_cnt == c_os_mid);
      r_bit_tick <= (r_os_cnt == c_os_last);
    end else begin
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end
  end

  assign os_tick  = w_os_tick;
  assign mid_tick = r_mid_tick;
  assign bit_tick = r_bit_tick;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_generator.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : tb_baud_tick_generator
// | Brief   : Self-checking bench for baud_tick_generator with a cycle model.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_baud_tick_generator;

  localparam int DIV_W      = 16;
  localparam int FRAC_W     = 4;
  localparam int OVERSAMPLE = 4;
  localparam int DEF_DIV    = 5;
  localparam int DEF_FRAC   = 0;

  logic              clk_in   = 1'b0;
  logic              reset    = 1'b1;
  logic              enable   = 1'b0;
  logic              div_load = 1'b0;
  logic              resync   = 1'b0;
  logic [DIV_W-1:0]  div_int  = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int os_q[$];
  int mid_q[$];
  int bit_q[$];

  int m_div, m_frac, m_sh_div, m_sh_frac;
  int m_elapsed, m_acc, m_extra, m_nticks;
  bit m_busy, e_os, e_mid, e_bit;

  baud_tick_generator #(
    .DIV_W      (DIV_W),
    .FRAC_W     (FRAC_W),
    .OVERSAMPLE (OVERSAMPLE),
    .DEF_DIV    (DEF_DIV),
    .DEF_FRAC   (DEF_FRAC)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .div_load (div_load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .resync   (resync),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each period lasts max(D,2) cycles plus one when the previous
  // fractional sum overflowed; tick k of a phase is bit k mod OVERSAMPLE.
  initial begin
    bit tick_now;
    forever begin
      @(posedge clk_in);
      cyc++;
      tick_now = 1'b0;
      e_os = 1'b0; e_mid = 1'b0; e_bit = 1'b0;
      if (!reset) begin
        m_div = DEF_DIV; m_frac = DEF_FRAC; m_sh_div = 0; m_sh_frac = 0; m_busy = 1'b0;
        m_elapsed = 0; m_acc = 0; m_extra = 0; m_nticks = 0;
      end else begin
        if (!enable || resync) begin
          m_elapsed = 0; m_acc = 0; m_extra = 0; m_nticks = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == ((m_div < 2) ? 2 : m_div) + m_extra) begin
            tick_now = 1'b1;
            e_os  = 1'b1;
            e_mid = ((m_nticks % OVERSAMPLE) == OVERSAMPLE / 2 - 1);
            e_bit = ((m_nticks % OVERSAMPLE) == OVERSAMPLE - 1);
            m_nticks++;
            m_extra   = ((m_acc + m_frac) >= (1 << FRAC_W)) ? 1 : 0;
            m_acc     = (m_acc + m_frac) % (1 << FRAC_W);
            m_elapsed = 0;
          end
        end
        if (div_load) begin
          m_sh_div = int'(div_int); m_sh_frac = int'(div_frac); m_busy = 1'b1;
        end else if (m_busy && (tick_now || !enable)) begin
          m_div = m_sh_div; m_frac = m_sh_frac; m_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      check("os_tick", 32'(os_tick), 32'(e_os));
      check("mid_tick", 32'(mid_tick), 32'(e_mid));
      check("bit_tick", 32'(bit_tick), 32'(e_bit));
      check("busy", 32'(busy), 32'(m_busy));
      if (os_tick === 1'b1) os_q.push_back(cyc);
      if (mid_tick === 1'b1) mid_q.push_back(cyc);
      if (bit_tick === 1'b1) bit_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic load(input int d, input int f);
    @(negedge clk_in);
    div_int  = DIV_W'(d);
    div_frac = FRAC_W'(f);
    div_load = 1'b1;
    @(negedge clk_in);
    div_load = 1'b0;
  endtask

  task automatic pulse_resync();
    @(negedge clk_in);
    resync = 1'b1;
    @(negedge clk_in);
    resync = 1'b0;
  endtask

  task automatic wait_busy_low(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    check("busy_clear_wait", 32'(busy), 32'(0));
  endtask

  task automatic wait_os(input int n, input int budget);
    int k;
    k = 0;
    while (os_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check("os_tick_wait", 32'(os_q.size() >= n), 32'(1));
  endtask

  task automatic wait_bit(input int n, input int budget);
    int k;
    k = 0;
    while (bit_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check("bit_tick_wait", 32'(bit_q.size() >= n), 32'(1));
  endtask

  initial begin
    int t0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_outputs", 32'({os_tick, mid_tick, bit_tick, busy}), 32'(0));
    reset = 1'b1;

    // D=4, F=0, loaded while idle, then enabled
    load(4, 0);
    @(negedge clk_in);
    check("idle_load_applied", 32'(busy), 32'(0));
    os_q.delete(); mid_q.delete(); bit_q.delete();
    t0 = cyc;
    enable = 1'b1;
    wait_os(9, 60);
    check("t1_first_delay", os_q[0] - t0, 4);
    check("t1_period", os_q[1] - os_q[0], 4);
    check("t1_span8", os_q[8] - os_q[0], 32);
    check("t1_bit_on_4th", bit_q[0], os_q[3]);
    check("t1_bit_period", bit_q[1] - bit_q[0], 16);
    check("t1_mid_after_bit", mid_q[1] - bit_q[0], 8);

    // D=4, F=8: periods 4,5,4,5...
    load(4, 8);
    wait_busy_low(20);
    os_q.delete();
    wait_os(33, 200);
    check("t2_period_a", os_q[1] - os_q[0], 4);
    check("t2_period_b", os_q[2] - os_q[1], 5);
    check("t2_span32", os_q[32] - os_q[0], 144);

    // Load D=6 two cycles into a D=4 period
    load(4, 0);
    wait_busy_low(20);
    pulse_resync();
    os_q.delete();
    wait_os(1, 20);
    @(negedge clk_in);
    @(negedge clk_in);
    div_int = DIV_W'(6); div_frac = '0; div_load = 1'b1;
    @(negedge clk_in);
    div_load = 1'b0;
    check("t3_busy_set", 32'(busy), 32'(1));
    wait_os(2, 20);
    check("t3_busy_cleared", 32'(busy), 32'(0));
    wait_os(3, 20);
    check("t3_old_period", os_q[1] - os_q[0], 4);
    check("t3_new_period", os_q[2] - os_q[1], 6);

    // Divisors below 2 clamp to 2
    load(0, 0);
    wait_busy_low(20);
    os_q.delete();
    wait_os(3, 20);
    check("t4_div0_a", os_q[1] - os_q[0], 2);
    check("t4_div0_b", os_q[2] - os_q[1], 2);
    load(1, 0);
    wait_busy_low(20);
    os_q.delete();
    wait_os(3, 20);
    check("t4_div1_a", os_q[1] - os_q[0], 2);
    check("t4_div1_b", os_q[2] - os_q[1], 2);

    // resync landing on a tick edge at os_cnt=2
    load(4, 0);
    wait_busy_low(20);
    pulse_resync();
    os_q.delete(); bit_q.delete();
    wait_os(2, 20);
    repeat (4) @(negedge clk_in);
    resync = 1'b1;
    t0 = cyc + 1;
    @(negedge clk_in);
    resync = 1'b0;
    wait_os(3, 20);
    check("t5_tick_after_resync", os_q[2] - t0, 4);
    wait_bit(1, 40);
    check("t5_bit_after_resync", bit_q[0] - t0, 16);

    // Reset mid-period with a load pending
    load(9, 0);
    check("t6_busy_pending", 32'(busy), 32'(1));
    @(negedge clk_in);
    reset = 1'b0;
    #1;
    check("t6_outputs_low", 32'({os_tick, mid_tick, bit_tick, busy}), 32'(0));
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
    t0 = cyc;
    os_q.delete();
    wait_os(3, 40);
    check("t6_first_delay", os_q[0] - t0, 5);
    check("t6_period_a", os_q[1] - os_q[0], 5);
    check("t6_period_b", os_q[2] - os_q[1], 5);
    check("t6_busy_idle", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
